benes_cfg_ctrl: RTL and testbench
=================================

Name: benes_cfg_ctrl

Overview:
- Configuration sequencer for the 8-port Benes fabric: 5 stages of 4 two-by-two switches each, one register of latency per stage.
- Collects a new route (switch settings) one stage at a time into shadow registers, with a valid/ready handshake.
- Applies the route as a wavefront aligned to frame_sync: stage k updates k*STAGE_LAT cycles after stage 0, so every in-flight frame sees one consistent route.
- Drives the per-stage switch_set buses.

Parameters:
NUM_STAGES, 5, number of fabric stages (2*log2(8)-1)
SW_PER_STAGE, 4, switches per stage; width of each cfg beat
STAGE_LAT, 1, clock cycles of latency per fabric stage

Ports:
clk  input  1  fabric clock, rising edge
rst_n  input  1  asynchronous active-low reset
cfg_valid  input  1  cfg beat valid
cfg_ready  output  1  controller accepts beat
cfg_stage  input  3  target stage index of beat
cfg_bits  input  SW_PER_STAGE  switch settings for that stage; bit i drives switch i
cfg_last  input  1  final beat of this route
frame_sync  input  1  first beat of a frame presented at stage 0 input this cycle
switch_set_o  output  NUM_STAGES*SW_PER_STAGE  active settings; stage k at bits [k*SW_PER_STAGE +: SW_PER_STAGE]
busy  output  1  high while not IDLE
applied  output  1  one-cycle pulse when the last stage has been updated
cfg_err  output  1  one-cycle pulse on a rejected beat

Behaviour:
- Reset (rst_n low, asynchronous):
  - State IDLE.
  - Active and shadow registers all 0 (bar/pass-through).
  - cfg_ready=1; busy, applied, cfg_err=0.
- Beat accepted on a clk edge with cfg_valid && cfg_ready.
- States:
  - IDLE: cfg_ready=1. An accepted beat moves to LOAD, or to ARMED if cfg_last.
  - LOAD: cfg_ready=1. Accepted beat writes shadow[cfg_stage]=cfg_bits. Unwritten stages keep their previous shadow value. An accepted beat with cfg_last moves to ARMED.
  - ARMED: cfg_ready=0. Waits for frame_sync. At the edge sampling frame_sync=1, active[0]<=shadow[0], cnt<=1, go APPLY.
  - APPLY: cfg_ready=0.
    - Each stage k>=1 is loaded at the edge k*STAGE_LAT cycles after the frame_sync edge (internal cycle counter).
    - At the edge loading stage NUM_STAGES-1: applied=1 for the following cycle, state goes to IDLE, cfg_ready=1.
    - With NUM_STAGES=5, STAGE_LAT=1: stage 0 at edge T, stage 4 at edge T+4, applied high in cycle T+4..T+5.
- Out-of-range beat (cfg_stage >= NUM_STAGES):
  - Shadow is not written; cfg_err pulses one cycle.
  - If cfg_last is set on that beat, the beat is still treated as last and the FSM moves to ARMED.
- frame_sync in IDLE, LOAD or APPLY is ignored. A mid-wavefront frame_sync does not restart the wavefront.
- Shadow writes are impossible during ARMED/APPLY because cfg_ready=0, so the wavefront always reads stable shadow data.
- Active registers change only during the APPLY wavefront or on reset. switch_set_o is driven straight from the active registers (no combinational path from inputs).
- busy = (state != IDLE).
- Reset asserted mid-LOAD or mid-APPLY clears everything immediately to reset values, including partially applied stages. No resumption after reset.
- Back-to-back routes: a new route may start in the cycle after applied, since cfg_ready is high then.

Optional Feature:
- Macro BENES_CFG_PARITY_EN.
- When defined:
  - Adds input cfg_par (1 bit) carrying even parity over cfg_bits.
  - An accepted beat whose ^{cfg_bits,cfg_par} != 0 is dropped entirely, including its cfg_last. Shadow is unchanged, cfg_err pulses, and the FSM stays in IDLE/LOAD.
  - Parity errors and out-of-range errors are reported on the same cfg_err.
- When undefined: no cfg_par port; no parity check.

Test Plan:
- Reset, then idle 10 cycles -> switch_set_o=20'h00000, cfg_ready=1, busy=0, applied=0.
- Load stages 0..4 with 4'hF,4'h1,4'h2,4'h4,4'h8 (cfg_last on stage 4); frame_sync at edge T -> stage 0=F at T, stage 1=1 at T+1, ..., stage 4=8 at T+4; applied pulses once; final switch_set_o=20'h8421F.
- Beat cfg_stage=6, cfg_bits=F mid-load -> cfg_err pulses one cycle; shadow unchanged; subsequent apply gives the same result as without that beat.
- frame_sync asserted while in LOAD, then a second frame_sync at T+2 during APPLY -> both ignored; wavefront timing still anchored to the first ARMED frame_sync.
- rst_n deasserted-to-low at T+2 of an APPLY -> switch_set_o=0 asynchronously; after release state is IDLE and no applied pulse occurs.
- With BENES_CFG_PARITY_EN: beat cfg_bits=4'h3, cfg_par=1, cfg_last=1 -> cfg_err pulses, FSM stays in LOAD; resend with cfg_par=0 -> ARMED.

Source files
------------

// File: rtl/benes_cfg_ctrl.sv
// ============================================================================
// benes_cfg_ctrl
// ----------------------------------------------------------------------------
// Configuration sequencer for an 8-port Benes fabric made of NUM_STAGES
// pipelined stages of SW_PER_STAGE 2x2 switches.
//
// A new route arrives one stage per beat over a valid/ready handshake. Each
// beat is collected into a shadow register for that stage. When the last beat
// has been taken, the controller waits for frame_sync and then copies the
// shadow route into the active registers as a wavefront. Stage k is updated
// k*STAGE_LAT cycles after stage 0, so it changes exactly when the first beat
// of the synchronised frame reaches it. Every frame in flight therefore sees
// one consistent route.
//
// Ports:
//   clk           fabric clock, rising edge
//   rst_n         asynchronous active-low reset
//   cfg_valid     cfg beat valid
//   cfg_ready     controller accepts a beat (high in IDLE and LOAD)
//   cfg_stage     target stage index of the beat
//   cfg_bits      switch settings for that stage; bit i drives switch i
//   cfg_last      final beat of this route
//   cfg_par       even parity over cfg_bits (only with BENES_CFG_PARITY_EN)
//   frame_sync    first beat of a frame is at the stage 0 input this cycle
//   switch_set_o  active settings; stage k at [k*SW_PER_STAGE +: SW_PER_STAGE]
//   busy          high while the FSM is not IDLE
//   applied       one-cycle pulse after the last stage has been updated
//   cfg_err       one-cycle pulse after a rejected beat
//
// Build option:
//   BENES_CFG_PARITY_EN  adds cfg_par. An accepted beat with bad parity is
//                        dropped entirely, including its cfg_last.
// ============================================================================
module benes_cfg_ctrl #(
    parameter int NUM_STAGES   = 5,
    parameter int SW_PER_STAGE = 4,
    parameter int STAGE_LAT    = 1
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               cfg_valid,
    output logic                               cfg_ready,
    input  logic [2:0]                         cfg_stage,
    input  logic [SW_PER_STAGE-1:0]            cfg_bits,
    input  logic                               cfg_last,
`ifdef BENES_CFG_PARITY_EN
    input  logic                               cfg_par,
`endif
    input  logic                               frame_sync,
    output logic [NUM_STAGES*SW_PER_STAGE-1:0] switch_set_o,
    output logic                               busy,
    output logic                               applied,
    output logic                               cfg_err
);

    // The cycle counter measures edges since the frame_sync edge.
    // The last stage loads when the count reaches LAST_CNT.
    localparam int LAST_CNT = (NUM_STAGES - 1) * STAGE_LAT;
    localparam int CNT_W    = (LAST_CNT < 2) ? 1 : $clog2(LAST_CNT + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        ARMED = 2'd2,
        APPLY = 2'd3
    } state_e;

    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    applied_q, applied_d;
    logic                    cfg_err_q, cfg_err_d;

    logic [SW_PER_STAGE-1:0] shadow_q [NUM_STAGES];
    logic [SW_PER_STAGE-1:0] active_q [NUM_STAGES];
    logic [NUM_STAGES-1:0]   shadow_we;
    logic [NUM_STAGES-1:0]   active_ld;

    logic accept;
    logic in_range;
    logic par_ok;
    logic beat_ok;

    assign cfg_ready = (state_q == IDLE) || (state_q == LOAD);
    assign accept    = cfg_valid && cfg_ready;
    assign in_range  = (32'(cfg_stage) < 32'(NUM_STAGES));

`ifdef BENES_CFG_PARITY_EN
    assign par_ok = ~(^{cfg_bits, cfg_par});
`else
    assign par_ok = 1'b1;
`endif

    // A beat with good parity still counts toward the route, even if its stage
    // index is out of range. Its cfg_last must still arm the controller.
    assign beat_ok = accept && par_ok;

    // ------------------------------------------------------------------
    // Per-stage shadow and active registers
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < NUM_STAGES; gi++) begin : g_stage
            assign shadow_we[gi] = beat_ok && in_range && (cfg_stage == 3'(gi));

            // Stage 0 loads on the frame_sync edge. Later stages are delayed
            // by their depth in the pipeline.
            if (gi == 0) begin : g_first
                assign active_ld[gi] = (state_q == ARMED) && frame_sync;
            end else begin : g_rest
                assign active_ld[gi] = (state_q == APPLY) &&
                                       (cnt_q == CNT_W'(gi * STAGE_LAT));
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    shadow_q[gi] <= '0;
                    active_q[gi] <= '0;
                end else begin
                    if (shadow_we[gi]) begin
                        shadow_q[gi] <= cfg_bits;
                    end
                    if (active_ld[gi]) begin
                        active_q[gi] <= shadow_q[gi];
                    end
                end
            end

            assign switch_set_o[gi*SW_PER_STAGE +: SW_PER_STAGE] = active_q[gi];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            applied_q <= 1'b0;
            cfg_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            applied_q <= applied_d;
            cfg_err_q <= cfg_err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        applied_d = 1'b0;
        cfg_err_d = accept && (!par_ok || !in_range);

        case (state_q)
            IDLE, LOAD: begin
                if (beat_ok) begin
                    state_d = cfg_last ? ARMED : LOAD;
                end
            end
            ARMED: begin
                if (frame_sync) begin
                    state_d = APPLY;
                    cnt_d   = CNT_W'(1);
                end
            end
            APPLY: begin
                // frame_sync is ignored here, so the wavefront is never
                // restarted once it has begun.
                if (cnt_q == CNT_W'(LAST_CNT)) begin
                    state_d   = IDLE;
                    cnt_d     = '0;
                    applied_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign busy    = (state_q != IDLE);
    assign applied = applied_q;
    assign cfg_err = cfg_err_q;

endmodule

// File: tb/tb_benes_cfg_ctrl.sv
// ============================================================================
// tb_benes_cfg_ctrl
// Directed testbench for benes_cfg_ctrl (NUM_STAGES=5, SW_PER_STAGE=4,
// STAGE_LAT=1). Inputs are driven 1ns after each rising edge, and outputs are
// sampled at the same point.
// ============================================================================
module tb_benes_cfg_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        cfg_valid = 1'b0;
    logic [2:0]  cfg_stage = 3'd0;
    logic [3:0]  cfg_bits = 4'd0;
    logic        cfg_last = 1'b0;
    logic        frame_sync = 1'b0;
`ifdef BENES_CFG_PARITY_EN
    logic        cfg_par = 1'b0;
`endif
    logic        cfg_ready;
    logic [19:0] switch_set_o;
    logic        busy;
    logic        applied;
    logic        cfg_err;

    int errors = 0;
    int checks = 0;

    // Wavefront observations at edges T..T+4 (T = frame_sync edge).
    logic [19:0] obs_sw   [5];
    logic        obs_ap   [5];
    logic        obs_busy [5];

    benes_cfg_ctrl #(
        .NUM_STAGES  (5),
        .SW_PER_STAGE(4),
        .STAGE_LAT   (1)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_stage   (cfg_stage),
        .cfg_bits    (cfg_bits),
        .cfg_last    (cfg_last),
`ifdef BENES_CFG_PARITY_EN
        .cfg_par     (cfg_par),
`endif
        .frame_sync  (frame_sync),
        .switch_set_o(switch_set_o),
        .busy        (busy),
        .applied     (applied),
        .cfg_err     (cfg_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Present one beat for one edge. Parity is always correct here.
    task automatic send(input logic [2:0] st, input logic [3:0] b, input logic lst);
        cfg_valid = 1'b1;
        cfg_stage = st;
        cfg_bits  = b;
        cfg_last  = lst;
`ifdef BENES_CFG_PARITY_EN
        cfg_par   = ^b;
`endif
        tick();
        cfg_valid = 1'b0;
        cfg_last  = 1'b0;
        $display("beat stage=%0d bits=%h last=%0d -> busy=%0d ready=%0d err=%0d",
                 st, b, lst, busy, cfg_ready, cfg_err);
    endtask

    // Raise frame_sync for one edge (T), then record edges T..T+4.
    // A second frame_sync is presented at edge T+resync_at if that is 1..4.
    task automatic capture_wave(input int resync_at);
        frame_sync = 1'b1;
        tick();
        frame_sync = 1'b0;
        obs_sw[0] = switch_set_o; obs_ap[0] = applied; obs_busy[0] = busy;
        for (int i = 1; i < 5; i++) begin
            if (i == resync_at) frame_sync = 1'b1;
            tick();
            frame_sync = 1'b0;
            obs_sw[i] = switch_set_o; obs_ap[i] = applied; obs_busy[i] = busy;
        end
        $display("wave captured final=%h", obs_sw[4]);
    endtask

    // Expected active value at edge T+i: stages 0..i come from the new route.
    function automatic logic [19:0] exp_at(input logic [19:0] prev,
                                           input logic [19:0] route, input int i);
        logic [19:0] r;
        r = prev;
        for (int j = 0; j < 5; j++)
            if (j <= i) r[j*4 +: 4] = route[j*4 +: 4];
        return r;
    endfunction

    task automatic test_reset;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        repeat (10) tick();
        checks++; if (switch_set_o !== 20'h00000) begin errors++; $display("FAIL reset_sw got=%h exp=%h", switch_set_o, 20'h0); end
        checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", cfg_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (applied !== 1'b0) begin errors++; $display("FAIL reset_applied got=%b exp=0", applied); end
        checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", cfg_err); end
    endtask

    task automatic test_route;
        send(3'd0, 4'hF, 1'b0);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL route_busy got=%b exp=1", busy); end
        checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL route_ready_load got=%b exp=1", cfg_ready); end
        send(3'd1, 4'h1, 1'b0);
        send(3'd2, 4'h2, 1'b0);
        send(3'd3, 4'h4, 1'b0);
        send(3'd4, 4'h8, 1'b1);
        checks++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL route_ready_armed got=%b exp=0", cfg_ready); end
        // A beat offered while ARMED must not be taken.
        cfg_valid = 1'b1; cfg_stage = 3'd0; cfg_bits = 4'h0;
`ifdef BENES_CFG_PARITY_EN
        cfg_par = 1'b0;
`endif
        tick();
        cfg_valid = 1'b0;
        repeat (2) tick();
        checks++; if (switch_set_o !== 20'h00000) begin errors++; $display("FAIL route_armed_sw got=%h exp=%h", switch_set_o, 20'h0); end
        checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL route_armed_err got=%b exp=0", cfg_err); end
        capture_wave(-1);
        for (int i = 0; i < 5; i++) begin
            checks++; if (obs_sw[i] !== exp_at(20'h0, 20'h8421F, i)) begin errors++; $display("FAIL route_sw_T+%0d got=%h exp=%h", i, obs_sw[i], exp_at(20'h0, 20'h8421F, i)); end
            checks++; if (obs_ap[i] !== (i == 4)) begin errors++; $display("FAIL route_applied_T+%0d got=%b exp=%b", i, obs_ap[i], (i == 4)); end
            checks++; if (obs_busy[i] !== (i < 4)) begin errors++; $display("FAIL route_busy_T+%0d got=%b exp=%b", i, obs_busy[i], (i < 4)); end
        end
        tick();
        checks++; if (applied !== 1'b0) begin errors++; $display("FAIL route_applied_drop got=%b exp=0", applied); end
        checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL route_ready_end got=%b exp=1", cfg_ready); end
    endtask

    task automatic test_bad_stage;
        send(3'd0, 4'hA, 1'b0);
        send(3'd1, 4'h5, 1'b0);
        send(3'd2, 4'h3, 1'b0);
        send(3'd3, 4'hC, 1'b0);
        send(3'd6, 4'hF, 1'b0);
        checks++; if (cfg_err !== 1'b1) begin errors++; $display("FAIL bad_stage_err got=%b exp=1", cfg_err); end
        checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL bad_stage_ready got=%b exp=1", cfg_ready); end
        tick();
        checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL bad_stage_err_drop got=%b exp=0", cfg_err); end
        send(3'd4, 4'h6, 1'b1);
        checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL bad_stage_good_err got=%b exp=0", cfg_err); end
        capture_wave(-1);
        for (int i = 0; i < 5; i++) begin
            checks++; if (obs_sw[i] !== exp_at(20'h8421F, 20'h6C35A, i)) begin errors++; $display("FAIL bad_stage_sw_T+%0d got=%h exp=%h", i, obs_sw[i], exp_at(20'h8421F, 20'h6C35A, i)); end
        end
        tick();
    endtask

    // Out-of-range beat carrying cfg_last still arms. Unwritten stages keep
    // their previous shadow contents.
    task automatic test_oor_last;
        send(3'd2, 4'h9, 1'b0);
        send(3'd7, 4'h0, 1'b1);
        checks++; if (cfg_err !== 1'b1) begin errors++; $display("FAIL oor_last_err got=%b exp=1", cfg_err); end
        checks++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL oor_last_armed got=%b exp=0", cfg_ready); end
        capture_wave(-1);
        for (int i = 0; i < 5; i++) begin
            checks++; if (obs_sw[i] !== exp_at(20'h6C35A, 20'h6C95A, i)) begin errors++; $display("FAIL oor_last_sw_T+%0d got=%h exp=%h", i, obs_sw[i], exp_at(20'h6C35A, 20'h6C95A, i)); end
        end
        checks++; if (obs_ap[4] !== 1'b1) begin errors++; $display("FAIL oor_last_applied got=%b exp=1", obs_ap[4]); end
        tick();
    endtask

    task automatic test_frame_sync_ignore;
        send(3'd0, 4'h1, 1'b0);
        frame_sync = 1'b1;
        tick();
        frame_sync = 1'b0;
        checks++; if (switch_set_o !== 20'h6C95A) begin errors++; $display("FAIL fs_load_sw got=%h exp=%h", switch_set_o, 20'h6C95A); end
        checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL fs_load_ready got=%b exp=1", cfg_ready); end
        send(3'd1, 4'h2, 1'b0);
        send(3'd2, 4'h3, 1'b0);
        send(3'd3, 4'h4, 1'b0);
        send(3'd4, 4'h5, 1'b1);
        capture_wave(2);
        for (int i = 0; i < 5; i++) begin
            checks++; if (obs_sw[i] !== exp_at(20'h6C95A, 20'h54321, i)) begin errors++; $display("FAIL fs_sw_T+%0d got=%h exp=%h", i, obs_sw[i], exp_at(20'h6C95A, 20'h54321, i)); end
            checks++; if (obs_ap[i] !== (i == 4)) begin errors++; $display("FAIL fs_applied_T+%0d got=%b exp=%b", i, obs_ap[i], (i == 4)); end
        end
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL fs_busy_end got=%b exp=0", busy); end
    endtask

    task automatic test_reset_mid_apply;
        for (int s = 0; s < 5; s++) send(3'(s), 4'h7, (s == 4));
        frame_sync = 1'b1;
        tick();
        frame_sync = 1'b0;
        tick();
        checks++; if (switch_set_o !== 20'h54377) begin errors++; $display("FAIL rst_mid_pre_sw got=%h exp=%h", switch_set_o, 20'h54377); end
        #3 rst_n = 1'b0;
        #1;
        checks++; if (switch_set_o !== 20'h00000) begin errors++; $display("FAIL rst_mid_async_sw got=%h exp=%h", switch_set_o, 20'h0); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy got=%b exp=0", busy); end
        checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_ready got=%b exp=1", cfg_ready); end
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++; if (applied !== 1'b0) begin errors++; $display("FAIL rst_mid_applied_c%0d got=%b exp=0", i, applied); end
            checks++; if (switch_set_o !== 20'h00000) begin errors++; $display("FAIL rst_mid_sw_c%0d got=%h exp=%h", i, switch_set_o, 20'h0); end
        end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy_after got=%b exp=0", busy); end
    endtask

    task automatic test_back_to_back;
        send(3'd0, 4'h5, 1'b0);
        send(3'd1, 4'h6, 1'b0);
        send(3'd2, 4'h7, 1'b0);
        send(3'd3, 4'h8, 1'b0);
        send(3'd4, 4'h9, 1'b1);
        capture_wave(-1);
        checks++; if (obs_sw[4] !== 20'h98765) begin errors++; $display("FAIL b2b_first_sw got=%h exp=%h", obs_sw[4], 20'h98765); end
        checks++; if (obs_ap[4] !== 1'b1) begin errors++; $display("FAIL b2b_first_applied got=%b exp=1", obs_ap[4]); end
        // Beat presented in the same cycle that applied is high.
        send(3'd0, 4'hE, 1'b0);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_accept_busy got=%b exp=1", busy); end
        checks++; if (applied !== 1'b0) begin errors++; $display("FAIL b2b_applied_drop got=%b exp=0", applied); end
        send(3'd1, 4'hD, 1'b0);
        send(3'd2, 4'hB, 1'b0);
        send(3'd3, 4'h7, 1'b0);
        send(3'd4, 4'h0, 1'b1);
        capture_wave(-1);
        for (int i = 0; i < 5; i++) begin
            checks++; if (obs_sw[i] !== exp_at(20'h98765, 20'h07BDE, i)) begin errors++; $display("FAIL b2b_sw_T+%0d got=%h exp=%h", i, obs_sw[i], exp_at(20'h98765, 20'h07BDE, i)); end
        end
        tick();
    endtask

`ifdef BENES_CFG_PARITY_EN
    task automatic test_parity;
        send(3'd1, 4'hD, 1'b0);
        cfg_valid = 1'b1; cfg_stage = 3'd0; cfg_bits = 4'h3; cfg_par = 1'b1; cfg_last = 1'b1;
        tick();
        cfg_valid = 1'b0; cfg_last = 1'b0;
        $display("beat stage=0 bits=3 par=1 last=1 -> err=%0d ready=%0d", cfg_err, cfg_ready);
        checks++; if (cfg_err !== 1'b1) begin errors++; $display("FAIL par_err got=%b exp=1", cfg_err); end
        checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL par_stay_load got=%b exp=1", cfg_ready); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL par_busy got=%b exp=1", busy); end
        cfg_valid = 1'b1; cfg_stage = 3'd0; cfg_bits = 4'h3; cfg_par = 1'b0; cfg_last = 1'b1;
        tick();
        cfg_valid = 1'b0; cfg_last = 1'b0;
        $display("beat stage=0 bits=3 par=0 last=1 -> err=%0d ready=%0d", cfg_err, cfg_ready);
        checks++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL par_armed got=%b exp=0", cfg_ready); end
        checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL par_good_err got=%b exp=0", cfg_err); end
        capture_wave(-1);
        checks++; if (obs_sw[4] !== 20'h07BD3) begin errors++; $display("FAIL par_sw got=%h exp=%h", obs_sw[4], 20'h07BD3); end
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_route();
        test_bad_stage();
        test_oor_last();
        test_frame_sync_ignore();
        test_reset_mid_apply();
        test_back_to_back();
`ifdef BENES_CFG_PARITY_EN
        test_parity();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
